// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Memory-stage data-bus responder: runs one load/store at a time on a valid/ready bus,
// steering byte lanes on the way out and extending load data on the way back.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  MemControlM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemErrM,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TMO_V = TIMEOUT[CW:0];

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic          req, is_wr, f3_ok, aligned, legal, tmo;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          err_q;
    logic [CW-1:0] cnt;
    logic [3:0]    strb_nxt;
    logic [31:0]   wdata_nxt, lane, ext;

    // Legality and lane steering for the request presented in IDLE
    always_comb begin
        req   = MemReadM | MemWriteM;
        is_wr = MemWriteM;
        if (is_wr) f3_ok = MemControlM inside {3'b000, 3'b001, 3'b010};
        else       f3_ok = MemControlM inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (MemControlM[1:0])
            2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
            2'b01:   aligned = !ALUResultM[0];
            default: aligned = 1'b1;
        endcase
        legal = f3_ok & aligned;
        case (MemControlM[1:0])
            2'b00: begin
                strb_nxt  = 4'b0001 << ALUResultM[1:0];
                wdata_nxt = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                strb_nxt  = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{WriteDataM[15:0]}};
            end
            default: begin
                strb_nxt  = 4'b1111;
                wdata_nxt = WriteDataM;
            end
        endcase
    end

    // Load return path uses the latched offset/funct3, not the live M-stage inputs
    always_comb begin
        lane = bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ext = {24'h0, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ext = {16'h0, lane[15:0]};
            default: ext = lane;
        endcase
        tmo = (TIMEOUT != 0) && (({1'b0, cnt} + 1'b1) == TMO_V);
    end

    always_comb begin
        state_nxt = state;
        StallM    = 1'b0;
        MemErrM   = 1'b0;
        case (state)
            IDLE: if (req) begin
                if (legal) begin
                    StallM    = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    MemErrM = 1'b1;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (bus_ready || tmo) state_nxt = DONE;
            end
            DONE: begin
                MemErrM   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Held request must not leak stall/error while reset is asserted
        if (!reset) begin
            StallM  = 1'b0;
            MemErrM = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
            ReadDataM <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            err_q     <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req && legal) begin
                    bus_valid <= 1'b1;
                    bus_we    <= is_wr;
                    bus_addr  <= {ALUResultM[31:2], 2'b00};
                    bus_wstrb <= is_wr ? strb_nxt : 4'b0000;
                    bus_wdata <= wdata_nxt;
                    f3_q      <= MemControlM;
                    off_q     <= ALUResultM[1:0];
                    cnt       <= '0;
                end
                BUSY: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (!bus_we) ReadDataM <= ext;
                        cnt <= '0;
                    end else if (tmo) begin
                        bus_valid <= 1'b0;
                        ReadDataM <= '0;
                        err_q     <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    cnt   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
